// File: rtl/counter_cmd_seq_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states and
// the bounce-direction helper.
package counter_cmd_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_BOUNCE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic DIR_UP = 1'b1;

    // Direction for the next bounce step: reverse at whichever end is reached.
    function automatic logic bounce_dir(input logic dir, input logic at_max, input logic at_zero);
        logic next_dir;
        if (dir == DIR_UP) begin
            next_dir = !at_max;
        end else begin
            next_dir = at_zero;
        end
        return next_dir;
    endfunction

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command handshake bundle between a command source and the counter sequencer.
interface counter_cmd_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_sat;
    logic             abort;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_sat, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_sat, abort,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_seq.sv
// Sequencer that turns LOAD / STEP_UP / STEP_DOWN / BOUNCE commands into
// load_n / ce / up_down controls for a downstream up/down counter.
module counter_cmd_seq
    import counter_cmd_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_cmd_seq_if.slave cmd,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic [WIDTH-1:0] data_load,
    output logic             ce,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    state_e           state_r;
    state_e           state_s;
    op_e              op_r;
    logic             sat_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] rem_r;
    logic             dir_r;
    logic             sat_hit_r;

    logic             accept_s;
    logic             stop_s;
    logic             step_s;
    logic             bounce_s;
    logic             run_dir_s;

    // Handshake, saturation stop and step qualification.
    always_comb begin
        accept_s = cmd.cmd_valid && (state_r == ST_IDLE);
        stop_s   = 1'b0;
        if (sat_r) begin
            case (op_r)
                OP_UP:   stop_s = max_count;
                OP_DOWN: stop_s = zero;
                default: stop_s = 1'b0;
            endcase
        end else begin
            stop_s = 1'b0;
        end
        bounce_s = bounce_dir(dir_r, max_count, zero);
        step_s   = (state_r == ST_RUN) && !stop_s && !cmd.abort;
        case (op_r)
            OP_UP:     run_dir_s = 1'b1;
            OP_DOWN:   run_dir_s = 1'b0;
            OP_BOUNCE: run_dir_s = bounce_s;
            default:   run_dir_s = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_e'(cmd.cmd_op) == OP_LOAD) begin
                        state_s = ST_LOAD;
                    end else if (cmd.cmd_data == ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_DONE;
            ST_RUN: begin
                if (cmd.abort || stop_s || (rem_r == ONE)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs; all decode the registered state so reset reaches them at once.
    always_comb begin
        cmd.cmd_ready = (state_r == ST_IDLE);
        load_n        = !((state_r == ST_LOAD) && !cmd.abort);
        ce            = step_s;
        up_down       = (state_r == ST_RUN) ? run_dir_s : 1'b1;
        busy          = (state_r == ST_LOAD) || (state_r == ST_RUN);
        done          = (state_r == ST_DONE);
        data_load     = data_r;
        sat_hit       = sat_hit_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch, remaining-step count, bounce direction and sticky sat_hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_LOAD;
            sat_r     <= 1'b0;
            data_r    <= ZERO;
            rem_r     <= ZERO;
            dir_r     <= DIR_UP;
            sat_hit_r <= 1'b0;
        end else if (accept_s) begin
            op_r      <= op_e'(cmd.cmd_op);
            sat_r     <= cmd.cmd_sat;
            data_r    <= cmd.cmd_data;
            rem_r     <= cmd.cmd_data;
            dir_r     <= DIR_UP;
            sat_hit_r <= 1'b0;
        end else begin
            if (step_s) begin
                rem_r <= rem_r - ONE;
                if (op_r == OP_BOUNCE) begin
                    dir_r <= bounce_s;
                end
            end
            if (((state_r == ST_LOAD) && cmd.abort) ||
                ((state_r == ST_RUN) && (cmd.abort || stop_s))) begin
                sat_hit_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench: drives commands into counter_cmd_seq, closes the loop
// through a 4-bit counter, and compares against a per-command reference model.
module tb_counter_cmd_seq;

    localparam int W = 4;
    localparam logic [1:0] OP_LD = 2'b00;
    localparam logic [1:0] OP_UP = 2'b01;
    localparam logic [1:0] OP_DN = 2'b10;
    localparam logic [1:0] OP_BO = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         max_count, zero, load_n, ce, up_down, busy, done, sat_hit;
    logic [W-1:0] data_load;
    logic [W-1:0] cnt = 4'h0;

    int checks = 0;
    int errors = 0;

    bit           ce_exp [0:31];
    bit           ud_exp [0:31];
    int           done_exp;
    bit           sathit_exp;
    logic [W-1:0] cnt_exp;
    logic [W-1:0] cnt_trace [0:31];
    int           steps_obs;

    counter_cmd_seq_if #(.WIDTH(W)) cif ();

    counter_cmd_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cif),
        .max_count (max_count),
        .zero      (zero),
        .load_n    (load_n),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done),
        .sat_hit   (sat_hit)
    );

    always #5 clk = ~clk;

    // Downstream counter that the sequencer drives.
    assign max_count = (cnt == 4'hF);
    assign zero      = (cnt == 4'h0);
    always @(posedge clk) begin
        if (!load_n) cnt <= data_load;
        else if (ce) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end

    // Reference: walks the counter value step by step from the command rules.
    task automatic model(input logic [1:0] op, input logic [3:0] n, input bit sat,
                         input int abort_at, input logic [3:0] c0);
        int   c;
        bit   dir;
        bit   ud;
        int   steps;
        for (int i = 0; i < 32; i++) begin
            ce_exp[i] = 1'b0;
            ud_exp[i] = 1'b1;
        end
        sathit_exp = 1'b0;
        c = int'(c0);
        if (op == OP_LD) begin
            done_exp = 2;
            if (abort_at == 1) begin
                sathit_exp = 1'b1;
                cnt_exp    = c0;
            end else begin
                cnt_exp = n;
            end
        end else if (n == 4'd0) begin
            done_exp = 1;
            cnt_exp  = c0;
        end else begin
            dir   = 1'b1;
            steps = 0;
            for (int t = 1; t < 32; t++) begin
                if (op == OP_UP) ud = 1'b1;
                else if (op == OP_DN) ud = 1'b0;
                else if (dir) ud = (c != 15);
                else ud = (c == 0);
                ud_exp[t] = ud;
                if ((abort_at == t) || (sat && op == OP_UP && c == 15) ||
                    (sat && op == OP_DN && c == 0)) begin
                    sathit_exp = 1'b1;
                    done_exp   = t + 1;
                    break;
                end
                ce_exp[t] = 1'b1;
                if (op == OP_BO) dir = ud;
                c = ud ? (c + 1) % 16 : (c + 15) % 16;
                steps++;
                if (steps == int'(n)) begin
                    done_exp = t + 1;
                    break;
                end
            end
            cnt_exp = c[3:0];
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input bit sat,
                           input int abort_at, input bit hold);
        int w;
        bit ln_exp;
        @(negedge clk);
        w = 0;
        while (!cif.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b want 1", cif.cmd_ready);
            return;
        end
        model(op, data, sat, abort_at, cnt);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        cif.cmd_sat   = sat;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        steps_obs = 0;
        for (int t = 1; t <= done_exp; t++) begin
            if (t > 1) @(negedge clk);
            cif.abort = (t == abort_at);
            if (hold && t == done_exp) begin
                cif.cmd_valid = 1'b1;
                cif.cmd_op    = 2'($urandom_range(0, 3));
                cif.cmd_data  = 4'($urandom_range(0, 15));
            end
            #1;
            cnt_trace[t] = cnt;
            if (ce) steps_obs++;
            ln_exp = !(op == OP_LD && t == 1 && abort_at != 1);
            checks++;
            if (ce !== ce_exp[t]) begin
                errors++;
                $display("FAIL ce op=%0d t=%0d got %b want %b", op, t, ce, ce_exp[t]);
            end
            checks++;
            if (up_down !== ud_exp[t]) begin
                errors++;
                $display("FAIL up_down op=%0d t=%0d got %b want %b", op, t, up_down, ud_exp[t]);
            end
            checks++;
            if (load_n !== ln_exp) begin
                errors++;
                $display("FAIL load_n op=%0d t=%0d got %b want %b", op, t, load_n, ln_exp);
            end
            checks++;
            if (done !== (t == done_exp)) begin
                errors++;
                $display("FAIL done op=%0d t=%0d got %b want %b", op, t, done, (t == done_exp));
            end
            checks++;
            if (busy !== (t < done_exp)) begin
                errors++;
                $display("FAIL busy op=%0d t=%0d got %b want %b", op, t, busy, (t < done_exp));
            end
            checks++;
            if (cif.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy t=%0d got %b want 0", t, cif.cmd_ready);
            end
        end
        checks++;
        if (sat_hit !== sathit_exp) begin
            errors++;
            $display("FAIL sat_hit op=%0d got %b want %b", op, sat_hit, sathit_exp);
        end
        @(negedge clk);
        cif.abort     = 1'b0;
        cif.cmd_valid = 1'b0;
        #1;
        checks++;
        if (cif.cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ready_after got ready=%b done=%b want 1/0", cif.cmd_ready, done);
        end
        checks++;
        if (cnt !== cnt_exp) begin
            errors++;
            $display("FAIL count op=%0d got %h want %h", op, cnt, cnt_exp);
        end
        checks++;
        if (data_load !== data) begin
            errors++;
            $display("FAIL data_load got %h want %h", data_load, data);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_data  = 4'h0;
        cif.cmd_sat   = 1'b0;
        cif.abort     = 1'b0;
        #1;
        checks++;
        if ({cif.cmd_ready, load_n, ce, up_down, busy, done, sat_hit, data_load} !== 11'b1101000_0000) begin
            errors++;
            $display("FAIL reset_outs got %b want 11010000000",
                     {cif.cmd_ready, load_n, ce, up_down, busy, done, sat_hit, data_load});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b want 1/0", cif.cmd_ready, busy);
        end
    endtask

    task automatic test_load;
        run_cmd(OP_LD, 4'hA, 1'b0, 0, 1'b0);
        checks++;
        if (cnt !== 4'hA) begin
            errors++;
            $display("FAIL load_value got %h want a", cnt);
        end
    endtask

    task automatic test_step_up;
        run_cmd(OP_LD, 4'h3, 1'b0, 0, 1'b0);
        run_cmd(OP_UP, 4'd5, 1'b0, 0, 1'b0);
        checks++;
        if (cnt !== 4'h8 || steps_obs != 5) begin
            errors++;
            $display("FAIL step_up got cnt=%h steps=%0d want 8/5", cnt, steps_obs);
        end
    endtask

    task automatic test_sat;
        run_cmd(OP_LD, 4'hD, 1'b0, 0, 1'b0);
        run_cmd(OP_UP, 4'd5, 1'b1, 0, 1'b0);
        checks++;
        if (cnt !== 4'hF || steps_obs != 2 || sat_hit !== 1'b1) begin
            errors++;
            $display("FAIL sat_up got cnt=%h steps=%0d sat_hit=%b want f/2/1", cnt, steps_obs, sat_hit);
        end
    endtask

    task automatic test_bounce;
        logic [3:0] seq [0:3];
        seq[0] = 4'hF; seq[1] = 4'hE; seq[2] = 4'hD; seq[3] = 4'hC;
        run_cmd(OP_LD, 4'hE, 1'b0, 0, 1'b0);
        run_cmd(OP_BO, 4'd4, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt_trace[i + 2] !== seq[i]) begin
                errors++;
                $display("FAIL bounce_seq i=%0d got %h want %h", i, cnt_trace[i + 2], seq[i]);
            end
        end
        checks++;
        if (sat_hit !== 1'b0) begin
            errors++;
            $display("FAIL bounce_sat got %b want 0", sat_hit);
        end
    endtask

    task automatic test_abort;
        run_cmd(OP_LD, 4'h7, 1'b0, 0, 1'b0);
        run_cmd(OP_DN, 4'd10, 1'b0, 3, 1'b0);
        checks++;
        if (steps_obs != 2 || sat_hit !== 1'b1 || cnt !== 4'h5) begin
            errors++;
            $display("FAIL abort got steps=%0d sat_hit=%b cnt=%h want 2/1/5", steps_obs, sat_hit, cnt);
        end
    endtask

    task automatic test_wrap;
        run_cmd(OP_LD, 4'hE, 1'b0, 0, 1'b0);
        run_cmd(OP_UP, 4'd4, 1'b0, 0, 1'b0);
        checks++;
        if (cnt !== 4'h2) begin
            errors++;
            $display("FAIL wrap_up got %h want 2", cnt);
        end
        run_cmd(OP_LD, 4'h1, 1'b0, 0, 1'b0);
        run_cmd(OP_DN, 4'd3, 1'b0, 0, 1'b0);
        checks++;
        if (cnt !== 4'hE) begin
            errors++;
            $display("FAIL wrap_down got %h want e", cnt);
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [3:0] data;
        bit         sat;
        int         ab;
        bit         hold;
        for (int k = 0; k < 40; k++) begin
            op   = 2'($urandom_range(0, 3));
            data = 4'($urandom_range(0, 15));
            sat  = 1'($urandom_range(0, 1));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0;
            hold = 1'($urandom_range(0, 1));
            run_cmd(op, data, sat, ab, hold);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [3:0] start;
        @(negedge clk);
        start = cnt;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_UP;
        cif.cmd_data  = 4'd10;
        cif.cmd_sat   = 1'b0;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cif.cmd_ready !== 1'b1 ||
            up_down !== 1'b1 || load_n !== 1'b1 || data_load !== 4'h0 || sat_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got ce=%b busy=%b done=%b ready=%b want 0/0/0/1",
                     ce, busy, done, cif.cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || ce !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold i=%0d got done=%b ce=%b want 0/0", i, done, ce);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cif.cmd_ready !== 1'b1 || cnt !== start + 4'd2) begin
            errors++;
            $display("FAIL reset_after got ready=%b cnt=%h want 1/%h", cif.cmd_ready, cnt, start + 4'd2);
        end
        run_cmd(OP_UP, 4'd0, 1'b0, 0, 1'b0);
        checks++;
        if (steps_obs != 0) begin
            errors++;
            $display("FAIL zero_steps got %0d want 0", steps_obs);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step_up();
        test_sat();
        test_bounce();
        test_abort();
        test_wrap();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 Parameter: WIDTH, 4, counter data width and step-count width; SHALL match the driven counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  SHALL be high only in IDLE.
REQ-006 cmd_op  in  2  opcode: 00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 BOUNCE.
REQ-007 cmd_data  in  WIDTH  load value (LOAD) or step count N (other ops).
REQ-008 cmd_sat  in  1  for STEP_UP/STEP_DOWN, stop early at counter limit instead of wrapping.
REQ-009 abort  in  1  synchronous cancel of the current command.
REQ-010 max_count  in  1  counter at all-ones, from the downstream counter.
REQ-011 zero  in  1  counter at zero, from the downstream counter.
REQ-012 load_n  out  1  active-low counter load.
REQ-013 data_load  out  WIDTH  counter load value.
REQ-014 ce  out  1  counter count enable.
REQ-015 up_down  out  1  counter direction (1 = up).
REQ-016 busy  out  1  high in LOAD and RUN.
REQ-017 done  out  1  one-cycle pulse at command completion.
REQ-018 sat_hit  out  1  sticky per command; cmd_sat or abort caused early termination.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-020 Command accept SHALL occur on cmd_valid && cmd_ready; op, data, and sat are latched; sat_hit cleared.
REQ-021 IDLE -> LOAD for op LOAD; IDLE -> RUN for other ops with N>0; IDLE -> DONE for N=0.
REQ-022 LOAD: load_n=0 and data_load=latched data for exactly one cycle, then DONE.
REQ-023 RUN: remaining-step register rem (WIDTH bits) is initialised to N; each cycle with ce=1 decrements rem; when the last step is taken, the next state is DONE.
REQ-024 ce SHALL be combinational: ce = (state==RUN) && !stop, where stop = latched sat && ((STEP_UP && max_count) || (STEP_DOWN && zero)).
REQ-025 A stop in RUN SHALL give ce=0 that cycle, set sat_hit, and go to DONE.
REQ-026 Without sat, STEP_UP/STEP_DOWN SHALL step through the counter's wrap (15->0, 0->15 at WIDTH=4).
REQ-027 BOUNCE: direction reg dir is initialised to up at accept; up_down = dir, except it is inverted when (dir up && max_count) or (dir down && zero); dir takes that value each step; all N steps are taken and there is no early stop.
REQ-028 up_down SHALL be 1 outside RUN; data_load SHALL hold the last latched value.
REQ-029 abort in LOAD or RUN SHALL suppress load_n and ce that cycle, set sat_hit, and go to DONE; abort is ignored in IDLE and DONE.
REQ-030 DONE: done=1 for one cycle, then IDLE; cmd_valid in DONE is not accepted.
REQ-031 Latency: for LOAD accepted at cycle T, load_n is low at T+1, done at T+2, and cmd_ready at T+3; for STEP N accepted at T, ce is high T+1..T+N and done at T+N+1.

Reset
REQ-032 Reset SHALL give: state=IDLE, cmd_ready=1, load_n=1, ce=0, up_down=1, data_load=0, busy=0, done=0, sat_hit=0, rem=0, dir=up.
REQ-033 Reset mid-command SHALL discard the command with no done pulse; outputs take reset values immediately (asynchronously).

Structure
REQ-034 The shared package counter_cmd_seq_pkg SHALL hold the opcode enum (op_e) and the state enum (state_e).
REQ-035 The block is a single module with no sub-module; it connects directly to the counter interface signals.

Verification
REQ-036 Reset; LOAD 0xA -> load_n low for one cycle with data_load=0xA; counter reads 0xA; done 2 cycles after accept.
REQ-037 Counter=3, STEP_UP N=5 sat=0 -> ce high for 5 cycles with up_down=1; counter=8; done at T+6.
REQ-038 Counter=13, STEP_UP N=5 sat=1 -> 2 steps; ce drops when max_count=1; counter=15; sat_hit=1; done pulse.
REQ-039 Counter=14, BOUNCE N=4 -> counter sequence 15, 14, 13, 12; done; sat_hit=0.
REQ-040 STEP_DOWN N=10 with abort at the 3rd RUN cycle -> 2 steps taken; sat_hit=1; done next cycle; cmd_ready follows.
REQ-041 rst_n low mid-RUN -> ce=0 and busy=0 immediately; no done pulse; cmd_ready=1 after release; STEP_UP N=0 afterwards gives done at T+1 with no ce.
